// File: rtl/loop_controller.sv
// loop_controller
//   Chooses the fetch unit's next PC around `[` / `]` loop instructions.
//   Keeps a return-address stack of loop-body start addresses. When `[` sees
//   a zero cell it skips forward to the matching `]` and squashes every
//   instruction it passes on the way.
//
// Optional feature macro: LOOP_CTRL_PERF_EN
//   When defined, jump_count counts taken backward jumps and saturates at
//   16'hFFFF. When undefined, jump_count is tied to zero and no counter
//   register exists.
//
// Handshake: there is no ready signal. An instruction is consumed on every
//   posedge where instr_valid=1 and hold=0. hold=1 freezes all state and
//   forces pc_write=0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_valid                instruction at the current pc is valid
//   is_loop_open/is_loop_close pre-decoded bracket flags
//   cell_zero                  current data cell == 0
//   hold                       downstream stall
//   pc_incremented             pc+1 from the fetch unit
//   pc_src                     0 = pc_incremented, 1 = pc_loaded
//   pc_write                   PC register enable
//   pc_loaded                  jump target (0 when pc_src=0)
//   squash                     suppress execute side effects
//   error                      sticky fault flag
//   loop_depth                 return-stack occupancy
//   jump_count                 taken backward jumps
//   state_dbg                  FSM state (0 RUN, 1 SKIP, 2 ERR)
module loop_controller #(
  parameter int PC_WIDTH    = 16,
  parameter int STACK_DEPTH = 16,
  parameter int SKIP_WIDTH  = 8,
  localparam int SP_W  = $clog2(STACK_DEPTH) + 1,
  localparam int IDX_W = $clog2(STACK_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic                is_loop_open,
  input  logic                is_loop_close,
  input  logic                cell_zero,
  input  logic                hold,
  input  logic [PC_WIDTH-1:0] pc_incremented,
  output logic                pc_src,
  output logic                pc_write,
  output logic [PC_WIDTH-1:0] pc_loaded,
  output logic                squash,
  output logic                error,
  output logic [SP_W-1:0]     loop_depth,
  output logic [15:0]         jump_count,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_SKIP = 2'd1, ST_ERR = 2'd2} state_t;

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  state_t                state;
  logic [SP_W-1:0]       sp;
  logic [SKIP_WIDTH-1:0] skip_depth;
  logic [PC_WIDTH-1:0]   stack_mem [STACK_DEPTH];

  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    top_idx;
  logic [PC_WIDTH-1:0] top_pc;
  logic stack_full, stack_empty;
  logic do_push, do_pop, go_err, go_skip, skip_inc, skip_dec, skip_exit;

  assign push_idx    = sp[IDX_W-1:0];
  // Wraps when sp==0; the value is unused then because `]` on an empty stack faults.
  assign top_idx     = IDX_W'(sp - SP_W'(1));
  assign top_pc      = stack_mem[top_idx];
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);

  always_comb begin
    pc_src    = 1'b0;
    pc_write  = 1'b0;
    squash    = (state != ST_RUN);
    do_push   = 1'b0;
    do_pop    = 1'b0;
    go_err    = 1'b0;
    go_skip   = 1'b0;
    skip_inc  = 1'b0;
    skip_dec  = 1'b0;
    skip_exit = 1'b0;
    if (reset) begin
      squash = 1'b1;
    end else if (hold) begin
      squash = 1'b0;
    end else if (instr_valid) begin
      case (state)
        ST_RUN: begin
          if (is_loop_open && is_loop_close) begin
            go_err = 1'b1;
            squash = 1'b1;
          end else if (is_loop_open) begin
            if (cell_zero) begin
              go_skip  = 1'b1;
              pc_write = 1'b1;
            end else if (stack_full) begin
              go_err = 1'b1;
              squash = 1'b1;
            end else begin
              do_push  = 1'b1;
              pc_write = 1'b1;
            end
          end else if (is_loop_close) begin
            if (stack_empty) begin
              go_err = 1'b1;
              squash = 1'b1;
            end else if (!cell_zero) begin
              // Taken backward jump: the entry stays for the next iteration.
              pc_src   = 1'b1;
              pc_write = 1'b1;
            end else begin
              do_pop   = 1'b1;
              pc_write = 1'b1;
            end
          end else begin
            pc_write = 1'b1;
          end
        end
        ST_SKIP: begin
          if (is_loop_open && is_loop_close) begin
            go_err = 1'b1;
          end else begin
            pc_write = 1'b1;
            if (is_loop_open) begin
              if (&skip_depth) go_err = 1'b1;
              else             skip_inc = 1'b1;
            end else if (is_loop_close) begin
              if (skip_depth == SKIP_WIDTH'(1)) skip_exit = 1'b1;
              else                              skip_dec  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_loaded = pc_src ? top_pc : '0;

  // Stack storage has no reset; only sp decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[push_idx] <= pc_incremented;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      sp         <= '0;
      skip_depth <= '0;
    end else if (go_err) begin
      state <= ST_ERR;
    end else begin
      if (go_skip) begin
        state      <= ST_SKIP;
        skip_depth <= SKIP_WIDTH'(1);
      end
      if (do_push)  sp <= sp + SP_W'(1);
      if (do_pop)   sp <= sp - SP_W'(1);
      if (skip_inc) skip_depth <= skip_depth + SKIP_WIDTH'(1);
      if (skip_dec) skip_depth <= skip_depth - SKIP_WIDTH'(1);
      if (skip_exit) begin
        state      <= ST_RUN;
        skip_depth <= '0;
      end
    end
  end

  assign error      = (state == ST_ERR);
  assign loop_depth = sp;
  assign state_dbg  = state;

`ifdef LOOP_CTRL_PERF_EN
  logic [15:0] jump_cnt_q;
  always_ff @(posedge clk) begin
    if (reset)                                 jump_cnt_q <= '0;
    else if (pc_src && jump_cnt_q != 16'hFFFF) jump_cnt_q <= jump_cnt_q + 16'd1;
  end
  assign jump_count = jump_cnt_q;
`else
  assign jump_count = 16'h0000;
`endif

endmodule

// File: doc/loop_controller.md
Name: loop_controller

Overview:
- Sequences the fetch unit's PC update for loop instructions `[` / `]`. It drives the PC mux select, the PC register write enable and the PC load value.
- Keeps a return-address stack of loop-body start addresses.
- On `[` with a zero cell, runs a forward bracket-matching skip scan, squashing execution of every instruction it passes.
- Sits between decode and the fetch unit; decode supplies pre-decoded bracket flags, so this block is independent of opcode encoding.

Parameters:
- PC_WIDTH, 16, width of PROGRAM_COUNTER values.
- STACK_DEPTH, 16, number of return-address entries (power of 2, ≥2).
- SKIP_WIDTH, 8, width of the skip nesting-depth counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction at current pc is valid this cycle
- is_loop_open  in  1  decoded `[` at current pc
- is_loop_close  in  1  decoded `]` at current pc
- cell_zero  in  1  current data cell == 0 (valid when instr_valid)
- hold  in  1  downstream stall; freeze PC and all state
- pc_incremented  in  PC_WIDTH  pc+1 from the fetch unit
- pc_src  out  1  0 = pc_incremented, 1 = pc_loaded
- pc_write  out  1  PC register enable
- pc_loaded  out  PC_WIDTH  jump target
- squash  out  1  suppress execute side effects of the current instruction
- error  out  1  sticky fault flag
- loop_depth  out  $clog2(STACK_DEPTH)+1  current stack occupancy
- jump_count  out  16  taken backward jumps (see Optional Feature)

Behaviour:
- Control outputs (pc_src, pc_write, pc_loaded, squash) are combinational from state and inputs. State updates on posedge clk.
- Reset state:
  - State RUN; sp=0; skip_depth=0; error=0; jump_count=0.
  - While reset is high: pc_write=0, pc_src=0, squash=1, pc_loaded=0.
- States: RUN, SKIP, ERR.
- Any state with hold=1: pc_write=0, squash=0; no state change.
- Any state with instr_valid=0 (and hold=0): pc_write=0; no state change.
- RUN, instr_valid=1, hold=0:
  - Neither bracket flag: pc_write=1, pc_src=0.
  - `[` with cell_zero=0 and stack not full: push pc_incremented; pc_write=1, pc_src=0.
  - `[` with cell_zero=0 and stack full: enter ERR; pc_write=0.
  - `[` with cell_zero=1: enter SKIP with skip_depth=1; pc_write=1, pc_src=0, squash=0 (the `[` itself has no side effect).
  - `]` with an empty stack: enter ERR; pc_write=0.
  - `]` with cell_zero=0: pc_src=1, pc_loaded=top of stack; no pop; pc_write=1.
  - `]` with cell_zero=1: pop; pc_write=1, pc_src=0.
- SKIP, instr_valid=1, hold=0:
  - Always pc_write=1, pc_src=0, squash=1; cell_zero is ignored.
  - `[`: skip_depth+1. If skip_depth is already all-ones, enter ERR instead.
  - `]` with skip_depth==1: return to RUN, skip_depth=0.
  - `]` otherwise: skip_depth-1.
  - Stack is untouched throughout SKIP.
- ERR:
  - pc_write=0, squash=1, error=1.
  - Held until reset.
- is_loop_open and is_loop_close both set: protocol violation; enter ERR.
- pc_loaded=0 whenever pc_src=0.
- Stack entries need no reset; only sp resets.
- Reset mid-SKIP or mid-loop: returns cleanly to RUN with an empty stack on the next edge.

Optional Feature:
- Macro: LOOP_CTRL_PERF_EN.
- Defined:
  - jump_count increments on each cycle with a taken backward jump (RUN, `]`, cell_zero=0, hold=0, instr_valid=1).
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined:
  - jump_count tied to 16'h0000.
  - No counter register is synthesized.

Test Plan:
- Reset released, stream of 4 non-bracket instructions at pc 0..3 → pc_write=1 and pc_src=0 each cycle; squash=0; loop_depth=0.
- `[` at pc=5 with cell_zero=0 (pc_incremented=6), then `]` at pc=9 with cell_zero=0 → push 6; then pc_src=1, pc_loaded=6, loop_depth=1. Repeat `]` with cell_zero=1 → pc_src=0, loop_depth=0.
- `[` at pc=2 with cell_zero=1, then sequence `+ [ - ] ]` → squash=1 for all five; skip_depth goes 1→2→1→0; RUN re-entered after the second `]`; the next instruction has squash=0.
- Push STACK_DEPTH=16 nested `[` with cell_zero=0, then a 17th `[` → error=1, pc_write=0; error persists until reset, then loop_depth=0.
- `]` with an empty stack → ERR. Separately: hold=1 during `]` with cell_zero=0 → pc_write=0, state and jump_count unchanged.
- With LOOP_CTRL_PERF_EN: 3 taken `]` jumps → jump_count=3. Without the macro → jump_count stays 0.
